// File: rtl/issue_scheduler.sv
// issue_scheduler: collapsing issue queue between rename and the functional units.
// Entry 0 is the oldest; valid entries are contiguous from 0 and tracked by count.
// Issues the oldest ready ALU op and the oldest MEM op (strictly in order) each cycle.
// Optional macro ISSUE_SCHED_PERF_EN adds saturating issue / full-stall counters.
module issue_scheduler #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned PREG_W  = 6,
    parameter int unsigned C_SIG_W = 7
) (
    input  logic                                clk_in,
    input  logic                                rst_n_in,
    input  logic                                flush_in,
    input  logic                                disp_valid_in,
    output logic                                disp_ready_out,
    input  logic [C_SIG_W-1:0]                  disp_c_sig_in,
    input  logic [11:0]                         disp_pc_in,
    input  logic [PREG_W-1:0]                   disp_dest_in,
    input  logic [PREG_W-1:0]                   disp_src1_in,
    input  logic [PREG_W-1:0]                   disp_src2_in,
    input  logic [1:0]                          disp_src_rdy_in,
    input  logic                                cmpl_valid_in,
    input  logic [PREG_W-1:0]                   cmpl_tag_in,
    output logic                                alu_valid_out,
    input  logic                                alu_ready_in,
    output logic [C_SIG_W+12+3*PREG_W-1:0]      alu_uop_out,
    output logic                                mem_valid_out,
    input  logic                                mem_ready_in,
    output logic [C_SIG_W+12+3*PREG_W-1:0]      mem_uop_out,
    output logic [$clog2(DEPTH):0]              count_out
`ifdef ISSUE_SCHED_PERF_EN
    ,
    output logic [15:0]                         perf_issued_out,
    output logic [15:0]                         perf_full_stall_out
`endif
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef struct packed {
        logic [C_SIG_W-1:0] c_sig;
        logic [11:0]        pc;
        logic [PREG_W-1:0]  dest;
        logic [PREG_W-1:0]  src1;
        logic [PREG_W-1:0]  src2;
        logic               rdy1;
        logic               rdy2;
    } entry_t;

    entry_t             q     [DEPTH];
    entry_t             q_nxt [DEPTH];
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_nxt;
    logic [CNT_W-1:0]   wptr;
    logic               alu_found;
    logic               mem_found;
    logic [IDX_W-1:0]   alu_idx;
    logic [IDX_W-1:0]   mem_idx;
    logic               alu_fire;
    logic               mem_fire;
    logic               disp_fire;
    entry_t             disp_entry;

    // Set ready bits of an entry whose source tag matches a completion broadcast.
    function automatic entry_t wake(input entry_t e, input logic v, input logic [PREG_W-1:0] tag);
        entry_t r;
        r      = e;
        r.rdy1 = e.rdy1 | (v && (e.src1 == tag));
        r.rdy2 = e.rdy2 | (v && (e.src2 == tag));
        return r;
    endfunction

    // Oldest ready ALU entry and oldest MEM entry, from registered state only.
    always_comb begin
        alu_found = 1'b0;
        mem_found = 1'b0;
        alu_idx   = '0;
        mem_idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count_q) begin
                if (q[i].c_sig[4:0] != 5'd0) begin
                    if (!mem_found) begin
                        mem_found = 1'b1;
                        mem_idx   = IDX_W'(i);
                    end
                end else if (!alu_found && q[i].rdy1 && q[i].rdy2) begin
                    alu_found = 1'b1;
                    alu_idx   = IDX_W'(i);
                end
            end
        end
    end

    assign alu_valid_out  = alu_found;
    assign mem_valid_out  = mem_found && q[mem_idx].rdy1 && q[mem_idx].rdy2;
    assign alu_uop_out    = {q[alu_idx].c_sig, q[alu_idx].pc, q[alu_idx].dest,
                             q[alu_idx].src1, q[alu_idx].src2};
    assign mem_uop_out    = {q[mem_idx].c_sig, q[mem_idx].pc, q[mem_idx].dest,
                             q[mem_idx].src1, q[mem_idx].src2};
    assign disp_ready_out = (count_q < CNT_W'(DEPTH));
    assign count_out      = count_q;

    assign alu_fire  = alu_valid_out && alu_ready_in;
    assign mem_fire  = mem_valid_out && mem_ready_in;
    assign disp_fire = disp_valid_in && disp_ready_out && !flush_in;

    // New entry: tag 0 and same-cycle completions count as ready.
    always_comb begin
        disp_entry.c_sig = disp_c_sig_in;
        disp_entry.pc    = disp_pc_in;
        disp_entry.dest  = disp_dest_in;
        disp_entry.src1  = disp_src1_in;
        disp_entry.src2  = disp_src2_in;
        disp_entry.rdy1  = disp_src_rdy_in[0] || (disp_src1_in == '0) ||
                           (cmpl_valid_in && (disp_src1_in == cmpl_tag_in));
        disp_entry.rdy2  = disp_src_rdy_in[1] || (disp_src2_in == '0) ||
                           (cmpl_valid_in && (disp_src2_in == cmpl_tag_in));
    end

    // Collapse out issued entries, apply wakeup, then append the dispatched entry.
    always_comb begin
        q_nxt = q;
        wptr  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) &&
                !(alu_fire && (alu_idx == IDX_W'(i))) &&
                !(mem_fire && (mem_idx == IDX_W'(i)))) begin
                q_nxt[wptr[IDX_W-1:0]] = wake(q[i], cmpl_valid_in, cmpl_tag_in);
                wptr = wptr + CNT_W'(1);
            end
        end
        if (disp_fire && (disp_c_sig_in != '0)) begin
            q_nxt[wptr[IDX_W-1:0]] = disp_entry;
            wptr = wptr + CNT_W'(1);
        end
        count_nxt = flush_in ? '0 : wptr;
    end

    // Queue storage and occupancy.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else begin
            count_q <= count_nxt;
            q       <= q_nxt;
        end
    end

`ifdef ISSUE_SCHED_PERF_EN
    logic [16:0] issued_sum;
    assign issued_sum = {1'b0, perf_issued_out} + 17'(alu_fire) + 17'(mem_fire);

    // Saturating performance counters; cleared by reset only.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            perf_issued_out     <= '0;
            perf_full_stall_out <= '0;
        end else begin
            perf_issued_out <= issued_sum[16] ? 16'hFFFF : issued_sum[15:0];
            if (disp_valid_in && !disp_ready_out && (perf_full_stall_out != 16'hFFFF)) begin
                perf_full_stall_out <= perf_full_stall_out + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- Centralised issue queue between decode/rename and the functional units of the out-of-order core.
- Buffers decoded micro-ops, carried as a 7-bit control signal plus a 12-bit PC with physical register tags.
- Tracks operand readiness from completion broadcasts.
- Each cycle, issues the oldest ready ALU op to the ALU port and the oldest memory op, in order, to the memory port.

Parameters:
- DEPTH, 8, number of queue entries (power of two, ≥2).
- PREG_W, 6, physical register tag width.
- C_SIG_W, 7, control signal width.

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
flush_in  input  1  synchronous squash of all entries
disp_valid_in  input  1  dispatch request
disp_ready_out  output  1  queue can accept a dispatch
disp_c_sig_in  input  C_SIG_W  decoded control signal
disp_pc_in  input  12  instruction PC
disp_dest_in  input  PREG_W  destination tag
disp_src1_in  input  PREG_W  source 1 tag
disp_src2_in  input  PREG_W  source 2 tag
disp_src_rdy_in  input  2  {src2,src1} already ready at rename
cmpl_valid_in  input  1  completion broadcast valid
cmpl_tag_in  input  PREG_W  completing destination tag
alu_valid_out  output  1  ALU issue valid
alu_ready_in  input  1  ALU accepts
alu_uop_out  output  C_SIG_W+12+3*PREG_W  packed {c_sig,pc,dest,src1,src2}
mem_valid_out  output  1  memory issue valid
mem_ready_in  input  1  LSU accepts
mem_uop_out  output  C_SIG_W+12+3*PREG_W  packed, same layout
count_out  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async, rst_n_in low):
  - All entry valid bits clear and count_out = 0.
  - alu_valid_out and mem_valid_out = 0; disp_ready_out = 1 after release.
  - Reset asserted mid-operation discards all contents immediately.
- Storage is a collapsing queue: entry 0 is oldest, and valid entries are contiguous from 0.
- Classification:
  - MEM if c_sig[4:0] != 0 (LB/LW/SB/SW encodings).
  - ALU if c_sig[4:0] == 0 and c_sig != 0.
  - c_sig == 0 is dropped at dispatch: it is accepted but not stored.
- Dispatch:
  - Fires when disp_valid_in && disp_ready_out.
  - disp_ready_out = (count_out < DEPTH), computed from registered count only; it does not account for a same-cycle issue.
  - The new entry is written at the tail after the cycle's collapse.
  - Its ready bits are disp_src_rdy_in OR'ed with a match against a same-cycle cmpl_tag_in.
- Wakeup:
  - When cmpl_valid_in is high, every valid entry with a matching src tag sets that ready bit at the next edge.
  - Tag 0 is treated as always ready.
- ALU select (combinational from registered state):
  - Picks the lowest-index valid ALU entry with both ready bits set.
  - alu_valid_out is high if such an entry exists; alu_uop_out carries it.
- MEM select:
  - Considers only the lowest-index valid MEM entry, which gives in-order memory issue.
  - mem_valid_out is high if that entry has both ready bits set; otherwise low even if younger MEM ops are ready.
- Issue:
  - A port fires on valid && ready; the fired entry is removed at the next edge.
  - Both ports may fire in the same cycle; entries above each removed slot shift down by 1 or 2 while preserving order.
  - valid_out may be high while ready_in is low; the uop stays stable until accepted unless an older op of that class becomes ready and displaces it (ALU only).
- Latency:
  - A dispatched entry is eligible one cycle after dispatch at the earliest.
  - A wakeup at cycle t makes the consumer eligible at t+1.
- Simultaneous events:
  - Issue removal, collapse, dispatch append and wakeup all take effect on the same edge.
  - A full queue with an issue in that cycle still refuses dispatch.
- flush_in:
  - Clears all entries at the next edge and overrides dispatch in that cycle.
  - Outputs that are valid during the flush cycle may still fire.
- count_out = count - issued + dispatched (0..DEPTH), with no wrap.

Optional Feature:
- Macro ISSUE_SCHED_PERF_EN.
- When defined, adds ports perf_issued_out (16-bit) and perf_full_stall_out (16-bit):
  - perf_issued_out counts uops issued on both ports, adding 2 when both ports fire in a cycle.
  - perf_full_stall_out counts cycles with disp_valid_in && !disp_ready_out.
  - Both saturate at 16'hFFFF and clear on reset, not on flush.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset then dispatch RTYPE (c_sig 7'b1000000, srcs ready) at cycle 1 → alu_valid_out=1 at cycle 2 with pc matching; alu_ready_in=1 → count_out returns to 0 at cycle 3.
- Dispatch LW (src1 tag 5, not ready) then SW (ready) → mem_valid_out=0 while SW waits behind LW; cmpl tag 5 → LW issues the next cycle, then SW.
- Dispatch two ALU ops: older op waits on tag 9, younger is ready → younger issues first; older issues one cycle after cmpl_tag_in=9.
- Fill 8 entries with unready ops → disp_ready_out=0 and count_out=8; with ISSUE_SCHED_PERF_EN, 3 blocked cycles → perf_full_stall_out=3.
- Ready ALU and MEM ops both present with both ready_in high → both fire in one cycle, remaining entries collapse by 2 and order is preserved.
- flush_in with 5 entries plus a simultaneous dispatch → count_out=0 next cycle and the dispatched uop is discarded; asynchronous rst_n_in low mid-issue → valid outputs drop immediately.
